// File: rtl/ig_pkg.sv
// Shared constants, types and arithmetic for the gradient-to-image reconstructor.
// Grad word layout: [2*G_W-1:G_W] = Gx, [G_W-1:0] = Gy, both two's complement.
package ig_pkg;

  localparam int IMG_W  = 256;
  localparam int IMG_H  = 256;
  localparam int PIX_W  = 8;
  localparam int G_W    = 10;
  localparam int GRAD_W = 2 * G_W;
  localparam int ADDR_W = 16;
  localparam int SUM_W  = G_W + 1;

  typedef logic [PIX_W-1:0]      pix_t;
  typedef logic signed [G_W-1:0] grad_t;
  typedef logic [GRAD_W-1:0]     grad_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_ROW0,
    ST_COLS,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    pix_t pix;
    logic ovf;
  } sat_t;

  function automatic grad_t get_gx(input grad_word_t w);
    return grad_t'(w[GRAD_W-1:G_W]);
  endfunction

  function automatic grad_t get_gy(input grad_word_t w);
    return grad_t'(w[G_W-1:0]);
  endfunction

  // Pixel is zero-extended and gradient sign-extended to SUM_W bits, then clamped.
  function automatic sat_t sat_add(input pix_t p, input grad_t g);
    logic signed [SUM_W-1:0] s;
    logic signed [SUM_W-1:0] pix_max;
    sat_t r;
    pix_max = SUM_W'(2 ** PIX_W - 1);
    s       = $signed(SUM_W'(p)) + SUM_W'(g);
    if (s[SUM_W-1]) begin
      r.pix = '0;
      r.ovf = 1'b1;
    end else if (s > pix_max) begin
      r.pix = '1;
      r.ovf = 1'b1;
    end else begin
      r.pix = s[PIX_W-1:0];
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/ig_reconstruct_if.sv
// Control, gradient-read and image-write signals of the reconstructor.
// master = the reconstructor, slave = host plus the two memories.
interface ig_reconstruct_if;
  import ig_pkg::*;

  logic               start;
  pix_t               seed;
  logic               busy;
  logic               done;
  logic               sat_err;
  logic               grad_rd;
  logic [ADDR_W-1:0]  grad_addr;
  grad_word_t         grad_di;
  logic               img_wr;
  logic [ADDR_W-1:0]  img_addr;
  pix_t               img_do;

  modport master (
    input  start, seed, grad_di,
    output busy, done, sat_err, grad_rd, grad_addr, img_wr, img_addr, img_do
  );

  modport slave (
    output start, seed, grad_di,
    input  busy, done, sat_err, grad_rd, grad_addr, img_wr, img_addr, img_do
  );

endinterface

// File: rtl/ig_line_buf.sv
// One-row pixel store: combinational read and synchronous write on a shared index,
// so a column can be read and replaced by its successor in the same cycle.
module ig_line_buf
  import ig_pkg::*;
#(
    parameter int DEPTH = IMG_W,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  pix_t             wd,
    output pix_t             rd
);

    // NOTE: no reset on the storage; every entry is written during SEED/ROW0 before any read uses it.
    pix_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wd;
    end

    assign rd = mem[idx];

endmodule

// File: rtl/ig_reconstruct.sv
// Rebuilds an image from its packed {Gx,Gy} gradients: row 0 integrates Gx from the
// seed, every later row adds Gy to the row above held in the line buffer.
module ig_reconstruct
    import ig_pkg::*;
#(
    parameter int FRAME_W = IMG_W,
    parameter int FRAME_H = IMG_H
) (
    input  logic              clk,
    input  logic              reset,
    ig_reconstruct_if.master  bus
);

    localparam int XW = $clog2(FRAME_W);
    localparam logic [ADDR_W-1:0] ROW0_LAST = ADDR_W'(FRAME_W - 2);
    localparam logic [ADDR_W-1:0] COLS_LAST = ADDR_W'(FRAME_W * (FRAME_H - 1) - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(FRAME_W);

    state_t            state;
    pix_t              seed_q;
    pix_t              prev;
    logic              rd_cols;
    logic              v2;
    logic              cols2;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] rd_next;

    logic              lb_we;
    logic [XW-1:0]     lb_idx;
    pix_t              lb_wd;
    pix_t              lb_rd;
    sat_t              sum;

    ig_line_buf #(.DEPTH(FRAME_W)) u_lbuf (
        .clk (clk),
        .we  (lb_we),
        .idx (lb_idx),
        .wd  (lb_wd),
        .rd  (lb_rd)
    );

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        rd_next = bus.grad_addr + ADDR_W'(1);
        sum     = sat_add(cols2 ? lb_rd : prev,
                          cols2 ? get_gy(bus.grad_di) : get_gx(bus.grad_di));
        lb_we   = !reset && (state == ST_SEED || v2);
        if (state == ST_SEED) begin
            lb_idx = '0;
            lb_wd  = seed_q;
        end else begin
            // Row 0 read x produces pixel x+1; a column read replaces its own entry.
            lb_idx = cols2 ? a2[XW-1:0] : a2[XW-1:0] + XW'(1);
            lb_wd  = sum.pix;
        end
    end

    // NOTE: all state here is sequential, so every assignment is non-blocking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.sat_err   <= 1'b0;
            bus.grad_rd   <= 1'b0;
            bus.grad_addr <= '0;
            bus.img_wr    <= 1'b0;
            bus.img_addr  <= '0;
            bus.img_do    <= '0;
            seed_q        <= '0;
            prev          <= '0;
            rd_cols       <= 1'b0;
            v2            <= 1'b0;
            cols2         <= 1'b0;
            a2            <= '0;
        end else begin
            // Stage 2 tracks the read the memory is sampling now; its data arrives next cycle.
            v2         <= bus.grad_rd;
            cols2      <= rd_cols;
            a2         <= bus.grad_addr;
            bus.img_wr <= 1'b0;

            if (v2) begin
                bus.img_wr   <= 1'b1;
                bus.img_do   <= sum.pix;
                bus.img_addr <= cols2 ? a2 + ROW_STEP : a2 + ADDR_W'(1);
                if (!cols2) prev <= sum.pix;
                if (sum.ovf) bus.sat_err <= 1'b1;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state       <= ST_SEED;
                        seed_q      <= bus.seed;
                        bus.busy    <= 1'b1;
                        bus.done    <= 1'b0;
                        bus.sat_err <= 1'b0;
                    end
                end
                ST_SEED: begin
                    bus.img_wr    <= 1'b1;
                    bus.img_addr  <= '0;
                    bus.img_do    <= seed_q;
                    prev          <= seed_q;
                    bus.grad_rd   <= 1'b1;
                    bus.grad_addr <= '0;
                    rd_cols       <= 1'b0;
                    state         <= ST_ROW0;
                end
                ST_ROW0: begin
                    bus.grad_addr <= rd_next;
                    if (rd_next == ROW0_LAST) state <= ST_COLS;
                end
                ST_COLS: begin
                    if (!rd_cols) begin
                        rd_cols       <= 1'b1;
                        bus.grad_addr <= '0;
                    end else begin
                        bus.grad_addr <= rd_next;
                        if (rd_next == COLS_LAST) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    bus.grad_rd <= 1'b0;
                    if (!bus.grad_rd && !v2) begin
                        state    <= ST_DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ig_reconstruct.sv
// Randomized scoreboard bench for ig_reconstruct on a reduced frame; expected images
// come from a direct integration of the gradient memory.
module tb_ig_reconstruct;
    import ig_pkg::*;

    localparam int TW = 32;
    localparam int TH = 64;
    localparam int N  = TW * TH;

    typedef struct {
        int addr;
        int data;
        int at;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   t0    = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   rd_idx = 0;
    int   rd_bad = 0;

    logic [GRAD_W-1:0] gmem [65536];
    int   src [N];
    int   ref_img [N];
    bit   ref_sat;
    exp_t exp_q [$];

    ig_reconstruct_if bus ();

    ig_reconstruct #(.FRAME_W(TW), .FRAME_H(TH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gradient memory: address sampled on the edge, data valid the following cycle.
    always @(posedge clk) begin
        if (bus.grad_rd) bus.grad_di <= gmem[bus.grad_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Write monitor pops the scoreboard; read monitor tallies sequence errors.
    always @(negedge clk) begin
        exp_t e;
        int   ea;
        if (bus.img_wr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("wr_addr[%0d]", e.addr), int'(bus.img_addr), e.addr);
                check($sformatf("wr_data[%0d]", e.addr), int'(bus.img_do), e.data);
                check($sformatf("wr_edge[%0d]", e.addr), cyc - t0, e.at);
            end
        end
        if (bus.grad_rd) begin
            ea = (rd_idx < TW - 1) ? rd_idx : rd_idx - (TW - 1);
            if (int'(bus.grad_addr) != ea || cyc - t0 != rd_idx + 1) rd_bad++;
            rd_idx++;
        end
    end

    function automatic int dec10(input logic [G_W-1:0] f);
        return f[G_W-1] ? int'(f) - 1024 : int'(f);
    endfunction

    function automatic int clamp(input int v);
        if (v < 0) begin
            ref_sat = 1'b1;
            return 0;
        end
        if (v > 255) begin
            ref_sat = 1'b1;
            return 255;
        end
        return v;
    endfunction

    // Reference: row 0 accumulates Gx from the seed, each lower pixel adds Gy to the one above.
    function automatic void build_ref(input int seed);
        ref_sat    = 1'b0;
        ref_img[0] = seed;
        for (int x = 1; x < TW; x++)
            ref_img[x] = clamp(ref_img[x-1] + dec10(gmem[x-1][GRAD_W-1:G_W]));
        for (int y = 1; y < TH; y++)
            for (int x = 0; x < TW; x++)
                ref_img[y*TW+x] = clamp(ref_img[(y-1)*TW+x] + dec10(gmem[(y-1)*TW+x][G_W-1:0]));
    endfunction

    // Forward gradients of src; the never-read last-column Gx and last-row Gy get junk.
    function automatic void grads_from_src();
        logic [G_W-1:0] fx, fy;
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++) begin
                fx = (x < TW - 1) ? G_W'(src[y*TW+x+1] - src[y*TW+x]) : G_W'($urandom);
                fy = (y < TH - 1) ? G_W'(src[(y+1)*TW+x] - src[y*TW+x]) : G_W'($urandom);
                gmem[y*TW+x] = {fx, fy};
            end
    endfunction

    function automatic void clear_grads();
        for (int a = 0; a < N; a++) gmem[a] = '0;
    endfunction

    task automatic run_frame(input int seed, input int reset_at, input int restart_at);
        int rel;
        int quiet;
        build_ref(seed);
        exp_q.delete();
        for (int k = 0; k < N; k++)
            exp_q.push_back('{addr: k, data: ref_img[k], at: (k == 0) ? 1 : k + 2});
        @(negedge clk);
        rd_idx    = 0;
        rd_bad    = 0;
        bus.start = 1'b1;
        bus.seed  = 8'(seed);
        t0        = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.seed  = 8'($urandom);
        check("busy_after_start", int'(bus.busy), 1);
        check("done_after_start", int'(bus.done), 0);
        check("sat_cleared_on_start", int'(bus.sat_err), 0);
        rel = 0;
        while (1) begin
            @(negedge clk);
            rel = cyc - t0;
            if (restart_at > 0 && rel == restart_at - 1) begin
                bus.start = 1'b1;
                bus.seed  = 8'(seed ^ 8'h5A);
            end else if (restart_at > 0 && rel == restart_at) begin
                bus.start = 1'b0;
            end
            if (reset_at > 0 && rel == reset_at - 1) reset = 1'b1;
            if (reset_at > 0 && rel == reset_at) break;
            if (bus.done || rel > N + 50) break;
        end
        if (reset_at > 0) begin
            check("reset_ctl_outputs", int'({bus.busy, bus.done, bus.sat_err, bus.grad_rd, bus.img_wr}), 0);
            check("reset_grad_addr", int'(bus.grad_addr), 0);
            check("reset_img_addr", int'(bus.img_addr), 0);
            check("reset_img_do", int'(bus.img_do), 0);
            exp_q.delete();
            reset = 1'b0;
            quiet = 0;
            repeat (30) begin
                @(negedge clk);
                if (bus.grad_rd || bus.img_wr || bus.busy) quiet++;
            end
            check("activity_after_reset", quiet, 0);
        end else begin
            check("done_edge", rel, N + 2);
            check("busy_at_done", int'(bus.busy), 0);
            check("writes_missing", exp_q.size(), 0);
            check("reads_seen", rd_idx, N - 1);
            check("read_seq_errors", rd_bad, 0);
            check("sat_err", int'(bus.sat_err), int'(ref_sat));
            repeat (5) @(negedge clk);
            check("done_level", int'(bus.done), 1);
            check("sat_err_sticky", int'(bus.sat_err), int'(ref_sat));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bus.start = 1'b0;
        bus.seed  = '0;
        for (int a = 0; a < 65536; a++) gmem[a] = '0;
        repeat (3) @(negedge clk);
        check("reset_ctl_outputs", int'({bus.busy, bus.done, bus.sat_err, bus.grad_rd, bus.img_wr}), 0);
        check("reset_addr_data", int'(bus.grad_addr) + int'(bus.img_addr) + int'(bus.img_do), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Flat image: zero gradients, seed everywhere.
        clear_grads();
        run_frame(100, 0, 0);

        // Diagonal ramp image round-trips exactly.
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++) src[y*TW+x] = (x + y) & 8'h7F;
        grads_from_src();
        run_frame(src[0], 0, 0);

        // Upper clamp on row 0.
        clear_grads();
        gmem[0] = {10'd10, 10'd0};
        run_frame(250, 0, 0);

        // Lower clamp down column 3.
        clear_grads();
        gmem[3] = {10'd0, 10'h200};
        run_frame(5, 0, 0);

        // Random image, aborted by reset at E1000, then rerun in full.
        for (int a = 0; a < N; a++) src[a] = int'($urandom_range(0, 255));
        grads_from_src();
        run_frame(src[0], 1000, 0);
        run_frame(src[0], 0, 0);

        // Raw random gradients with a start pulse while busy.
        for (int a = 0; a < N; a++) gmem[a] = GRAD_W'($urandom);
        s = int'($urandom_range(0, 255));
        run_frame(s, 0, 500);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ig_reconstruct.md
Name: ig_reconstruct

Overview:
Inverse of the image-gradient stage. It reads the 256x256 packed gradient memory {Gx,Gy} and integrates it, starting from a seed pixel, to rebuild the 8-bit image. It writes the rebuilt image to image memory in raster order. It sits downstream of the gradient memory and serves round-trip self-check and decompression.

Parameters:
IMG_W, 256, image width in pixels (power of 2)
IMG_H, 256, image height in rows
PIX_W, 8, pixel width (unsigned)
G_W, 10, width of each signed gradient field; grad word = 2*G_W

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle request; sampled only in IDLE/DONE
seed  in  8  pixel (0,0) value, sampled with start
busy  out  1  high from accepted start until done
done  out  1  level; high after last image write until next accepted start or reset
sat_err  out  1  sticky; set if any reconstructed pixel saturated; cleared on accepted start
grad_rd  out  1  gradient memory read strobe
grad_addr  out  16  gradient read address (y*IMG_W+x)
grad_di  in  20  gradient data, [19:10]=Gx signed, [9:0]=Gy signed; valid the cycle after the address/strobe is sampled
img_wr  out  1  image memory write strobe
img_addr  out  16  image write address
img_do  out  8  image write data

Behaviour:
- Reset: all outputs 0 (busy, done, sat_err, grad_rd, grad_addr, img_wr, img_addr, img_do). FSM goes to IDLE. Reset mid-operation aborts immediately; no further reads or writes.
- All outputs are registered.
- FSM states and transitions:
  - IDLE/DONE -> SEED on start.
  - SEED -> ROW0.
  - ROW0 -> COLS after read x=IMG_W-2 is issued.
  - COLS -> DRAIN after the last read is issued.
  - DRAIN -> DONE after 2 cycles.
- start while busy is ignored.
- Integration rules:
  - Row 0: p(x+1,0) = p(x,0) + Gx(x,0), for x=0..IMG_W-2.
  - Rows y>=1: p(x,y) = p(x,y-1) + Gy(x,y-1).
  - Gx of the last column and Gy of the last row are never read.
- Read sequence:
  - ROW0 reads grad addr 0..IMG_W-2 (255 reads).
  - COLS reads addr 0..IMG_W*(IMG_H-1)-1 (65280 reads).
  - Row 0 is read twice. Reads are contiguous, one per cycle, with no gap between phases.
- Line buffer: IMG_W x PIX_W holds the previous row. In COLS, read lbuf[x] and overwrite it with the new p(x,y) in the same cycle.
  - Row 0 pixels, seed included, are loaded during SEED/ROW0.
  - Running predecessor register prev for ROW0.
- Arithmetic: zero-extend the pixel to 11 bits, sign-extend the gradient to 11 bits, add, then saturate to [0,255]. Saturation sets sat_err.
- Timing (E0 = edge where start is sampled):
  - After E1: img_wr=1, addr 0, data seed; also grad_rd=1, grad_addr 0.
  - The read driven after E(1+j) is written after E(3+j).
  - No write occurs in the cycle after E2.
  - Image addr k (k>=1) is written after E(k+2); addr 65535 is written after E65537.
  - done=1 and busy=0 after E65538.
  - Exactly 65536 writes in increasing address order; exactly 65535 reads.
- grad_rd/img_wr are deasserted whenever no valid access is in that cycle; address and data hold their last values.

Decomposition:
- Package ig_pkg:
  - IMG_W, IMG_H, PIX_W, G_W constants.
  - Field extraction of Gx/Gy from a grad word.
  - sat_add function (pixel + signed gradient -> saturated pixel, overflow flag).
  - FSM state enum.
- One sub-module: ig_line_buf (IMG_W x PIX_W register array, one combinational read port, one synchronous write port on the same index).
- Read-issue counter, 2-stage valid/phase pipeline and FSM stay in the top.

Test Plan:
- Seed 100, all grads 0 -> 65536 writes all 100; sat_err=0; done after E65538.
- Image p(x,y)=(x+y)&0x7F, grads generated by the gradient stage, seed p(0,0) -> reconstruction bit-exact to the original at all addresses.
- Seed 250, Gx(0,0)=+10, other grads 0 -> img[1]=255, all others consistent with the clamped value; sat_err=1 until next start.
- Seed 5, Gy(3,0)=-512 (0x200) -> img[256+3]=0; column 3 rows 1..255 = 0; sat_err=1.
- Reset asserted at E1000 -> next cycle all outputs 0, no further writes; a new start runs a full, correct frame.
- start pulsed again at E500 while busy -> ignored; sequence and timing identical to a single-start run.
